fetch_stage: RTL

- IF stage of the MIPS pipeline, sitting directly upstream of Instruction_Memory.
- Owns the PC register and drives PC into Instruction_Memory.
- Captures the combinational Instruction_Code into the IF/ID pipeline register.
- Resolves unconditional J in ID: redirects PC and flushes the wrong-path fetch. Honours the hazard-unit stall.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_stage_if.sv | 41 ++++
 rtl/if_id_reg.sv | 59 +++++
 rtl/fetch_stage.sv | 125 ++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and jump-target helper for the IF stage
package fetch_pkg;

    localparam logic [5:0]  OPC_J     = 6'b000010;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Target of an unconditional J sitting in ID. pc4 is the J's own PC+4.
    // word_align=0 keeps the program's byte-address encoding of the target field;
    // word_align=1 is the architectural MIPS word-index form.
    function automatic logic [31:0] jump_target(
        input logic [31:0] pc4,
        input logic [31:0] instr,
        input logic        word_align
    );
        if (word_align) begin
            return {pc4[31:28], instr[25:0], 2'b00};
        end
        return {pc4[31:26], instr[25:0]};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory and IF/ID bus of the fetch stage
// Signals:
//   PC               fetch address to Instruction_Memory
//   Instruction_Code combinational instruction word for PC
//   IF_ID_Instr      latched instruction for ID
//   IF_ID_PC4        latched fetch PC + 4
//   IF_ID_Valid      1 = IF/ID holds a real instruction
//   jump_taken       J in ID is redirecting fetch this cycle
//   fetch_oob        registered out-of-range fetch flag
// master = fetch stage side, slave = memory/decode side.
interface fetch_stage_if;

    logic [31:0] PC;
    logic [31:0] Instruction_Code;
    logic [31:0] IF_ID_Instr;
    logic [31:0] IF_ID_PC4;
    logic        IF_ID_Valid;
    logic        jump_taken;
    logic        fetch_oob;

    modport master (
        output PC,
        input  Instruction_Code,
        output IF_ID_Instr,
        output IF_ID_PC4,
        output IF_ID_Valid,
        output jump_taken,
        output fetch_oob
    );

    modport slave (
        input  PC,
        output Instruction_Code,
        input  IF_ID_Instr,
        input  IF_ID_PC4,
        input  IF_ID_Valid,
        input  jump_taken,
        input  fetch_oob
    );

endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with hold and bubble controls
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   hold              keep current contents (highest priority after reset)
//   flush             load a bubble (NOP, PC4=0, valid=0)
//   instr_in, pc4_in  values captured on a normal edge (valid becomes 1)
//   instr, pc4, valid registered outputs
module if_id_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc4_in,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (hold) begin
            instr_d = instr_q;
        end else if (flush) begin
            instr_d = NOP_INSTR;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end else begin
            instr_d = instr_in;
            pc4_d   = pc4_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr = instr_q;
    assign pc4   = pc4_q;
    assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS IF stage: PC register, next-PC mux, J resolution in ID
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   stall  hazard-unit stall: hold PC and IF/ID, defer any J in ID
//   bus    fetch_stage_if.master (PC/Instruction_Code to memory, IF/ID to decode)
// Optional: FETCH_BOUND_CHECK_EN enables the IMEM_BYTES fetch bound check and
// drives fetch_oob; otherwise fetch_oob is tied 0.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          IMEM_BYTES      = 24,
    parameter int          JUMP_WORD_ALIGN = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    fetch_stage_if.master bus
);

    if (IMEM_BYTES < 4) begin : g_bad_imem_bytes
        $error("fetch_stage: IMEM_BYTES must hold at least one instruction");
    end

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic        jump_in_id;
    logic        jump_taken;
    logic        ifid_flush;

    assign pc_plus4   = pc_q + 32'd4;
    assign jump_in_id = id_valid && (id_instr[31:26] == OPC_J);
    assign jump_taken = jump_in_id && !stall;
    assign target     = jump_target(id_pc4, id_instr, JUMP_WORD_ALIGN != 0);

`ifdef FETCH_BOUND_CHECK_EN
    localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_BYTES);

    logic fetch_oob_q, fetch_oob_d;

    // 33-bit compare so an address near 2^32 cannot wrap into range.
    function automatic logic out_of_range(input logic [31:0] addr);
        return ({1'b0, addr} + 33'd3) >= IMEM_LIMIT;
    endfunction

    always_comb begin
        pc_d        = pc_q;
        fetch_oob_d = fetch_oob_q;
        ifid_flush  = 1'b0;
        if (stall) begin
            pc_d = pc_q;
        end else if (jump_taken) begin
            pc_d       = target;
            ifid_flush = 1'b1;
            if (!out_of_range(target)) begin
                fetch_oob_d = 1'b0;
            end
        end else if (out_of_range(pc_q)) begin
            // Park on the bad address and keep feeding bubbles until redirected.
            ifid_flush  = 1'b1;
            fetch_oob_d = 1'b1;
        end else begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_oob_q <= 1'b0;
        end else begin
            fetch_oob_q <= fetch_oob_d;
        end
    end

    assign bus.fetch_oob = fetch_oob_q;
`else
    always_comb begin
        pc_d       = pc_q;
        ifid_flush = 1'b0;
        if (stall) begin
            pc_d = pc_q;
        end else if (jump_taken) begin
            pc_d       = target;
            ifid_flush = 1'b1;
        end else begin
            pc_d = pc_plus4;
        end
    end

    assign bus.fetch_oob = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // A taken J flushes the wrong-path fetch currently at PC.
    if_id_reg u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .hold     (stall),
        .flush    (ifid_flush),
        .instr_in (bus.Instruction_Code),
        .pc4_in   (pc_plus4),
        .instr    (id_instr),
        .pc4      (id_pc4),
        .valid    (id_valid)
    );

    assign bus.PC          = pc_q;
    assign bus.IF_ID_Instr = id_instr;
    assign bus.IF_ID_PC4   = id_pc4;
    assign bus.IF_ID_Valid = id_valid;
    assign bus.jump_taken  = jump_taken;

endmodule
